// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ID/EX latch, logic/shift ALU,
// EX/MEM latch and the EX forwarding bus back to the decoder.
module ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        id_alusel_i,
  input  logic [7:0]        id_aluop_i,
  input  logic [DATA_W-1:0] id_reg1_i,
  input  logic [DATA_W-1:0] id_reg2_i,
  input  logic [ADDR_W-1:0] id_waddr_i,
  input  logic              id_we_i,
  input  logic              stall_i,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] ex_waddr_o,
  output logic              ex_we_o,
  output logic [DATA_W-1:0] ex_wdata_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o
);

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  localparam logic [7:0] EXE_OP_NOP_NOP = 8'b0000_0000;
  localparam logic [7:0] EXE_OP_AND     = 8'b0010_0100;
  localparam logic [7:0] EXE_OP_OR      = 8'b0010_0101;
  localparam logic [7:0] EXE_OP_XOR     = 8'b0010_0110;
  localparam logic [7:0] EXE_OP_NOR     = 8'b0010_0111;
  localparam logic [7:0] EXE_OP_SLL     = 8'b0111_1100;
  localparam logic [7:0] EXE_OP_SRL     = 8'b0000_0010;
  localparam logic [7:0] EXE_OP_SRA     = 8'b0000_0011;

  localparam int unsigned SA_W = 5;

  logic [2:0]        alusel_q;
  logic [7:0]        aluop_q;
  logic [DATA_W-1:0] reg1_q;
  logic [DATA_W-1:0] reg2_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              we_q;

  logic [ADDR_W-1:0] mem_waddr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [DATA_W-1:0] result;
  logic              valid;
  logic [SA_W-1:0]   sa;

  // ID/EX latch: any stall holds the instruction in EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alusel_q <= EXE_RES_NOP;
      aluop_q  <= EXE_OP_NOP_NOP;
      reg1_q   <= '0;
      reg2_q   <= '0;
      waddr_q  <= '0;
      we_q     <= 1'b0;
    end else if (flush_i) begin
      alusel_q <= EXE_RES_NOP;
      aluop_q  <= EXE_OP_NOP_NOP;
      reg1_q   <= '0;
      reg2_q   <= '0;
      waddr_q  <= '0;
      we_q     <= 1'b0;
    end else if (!(mem_stall_i || stall_i)) begin
      alusel_q <= id_alusel_i;
      aluop_q  <= id_aluop_i;
      reg1_q   <= id_reg1_i;
      reg2_q   <= id_reg2_i;
      waddr_q  <= id_waddr_i;
      we_q     <= id_we_i;
    end
  end

  assign sa = reg1_q[SA_W-1:0];

  always_comb begin
    result = '0;
    valid  = 1'b0;
    unique case (alusel_q)
      EXE_RES_LOGIC: begin
        valid = 1'b1;
        case (aluop_q)
          EXE_OP_AND: result = reg1_q & reg2_q;
          EXE_OP_OR:  result = reg1_q | reg2_q;
          EXE_OP_XOR: result = reg1_q ^ reg2_q;
          EXE_OP_NOR: result = ~(reg1_q | reg2_q);
          default:    valid  = 1'b0;
        endcase
      end
      EXE_RES_SHIFT: begin
        valid = 1'b1;
        case (aluop_q)
          EXE_OP_SLL: result = reg2_q << sa;
          EXE_OP_SRL: result = reg2_q >> sa;
          EXE_OP_SRA: result = DATA_W'($signed(reg2_q) >>> sa);
          default:    valid  = 1'b0;
        endcase
      end
      default: valid = 1'b0;
    endcase
  end

  // $0 is never forwarded or written back.
  assign ex_waddr_o = waddr_q;
  assign ex_we_o    = we_q & valid & (waddr_q != '0);
  assign ex_wdata_o = result;

  // EX/MEM latch: stall_i inserts a bubble, mem_stall_i freezes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_waddr_q <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else if (flush_i) begin
      mem_waddr_q <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else if (mem_stall_i) begin
      mem_waddr_q <= mem_waddr_q;
      mem_we_q    <= mem_we_q;
      mem_wdata_q <= mem_wdata_q;
    end else if (stall_i) begin
      mem_waddr_q <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      mem_waddr_q <= ex_waddr_o;
      mem_we_q    <= ex_we_o;
      mem_wdata_q <= ex_wdata_o;
    end
  end

  assign mem_waddr_o = mem_waddr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: reset, logic/shift ops, stalls,
// $0/invalid handling, flush and asynchronous reset.
module tb_ex_stage;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7c;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  id_alusel_i;
  logic [7:0]  id_aluop_i;
  logic [31:0] id_reg1_i, id_reg2_i;
  logic [4:0]  id_waddr_i;
  logic        id_we_i;
  logic        stall_i, mem_stall_i, flush_i;
  logic [4:0]  ex_waddr_o, mem_waddr_o;
  logic        ex_we_o, mem_we_o;
  logic [31:0] ex_wdata_o, mem_wdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_alusel_i(id_alusel_i), .id_aluop_i(id_aluop_i),
    .id_reg1_i(id_reg1_i), .id_reg2_i(id_reg2_i),
    .id_waddr_i(id_waddr_i), .id_we_i(id_we_i),
    .stall_i(stall_i), .mem_stall_i(mem_stall_i), .flush_i(flush_i),
    .ex_waddr_o(ex_waddr_o), .ex_we_o(ex_we_o), .ex_wdata_o(ex_wdata_o),
    .mem_waddr_o(mem_waddr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wa, input logic we);
    id_alusel_i = sel; id_aluop_i = op; id_reg1_i = r1; id_reg2_i = r2;
    id_waddr_i = wa; id_we_i = we;
  endtask

  task automatic nop();
    drive(RES_NOP, OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'($urandom), 8'($urandom), $urandom, $urandom, 5'($urandom), 1'b1);
      stall_i = 1'($urandom); mem_stall_i = 1'($urandom); flush_i = 1'($urandom);
      tick();
      n_checks++;
      if ({ex_waddr_o, ex_we_o, ex_wdata_o, mem_waddr_o, mem_we_o, mem_wdata_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: ex=%h/%b/%h mem=%h/%b/%h, need all 0", ex_waddr_o,
                 ex_we_o, ex_wdata_o, mem_waddr_o, mem_we_o, mem_wdata_o);
      end
    end
    nop(); stall_i = 0; mem_stall_i = 0; flush_i = 0;
    #2 rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (mem_we_o !== 1'b0 || ex_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_nops: mem_we=%b ex_we=%b, need 0/0", mem_we_o, ex_we_o);
    end
  endtask

  task automatic test_logic();
    drive(RES_LOGIC, OP_OR, 32'h0000_ff00, 32'h0000_00ff, 5'd3, 1'b1);
    tick();
    n_checks++;
    if (ex_wdata_o !== 32'h0000_ffff || ex_we_o !== 1'b1 || ex_waddr_o !== 5'd3) begin
      n_fail++;
      $display("FAIL or_ex: got %h/%b/%0d, need 0000ffff/1/3", ex_wdata_o, ex_we_o, ex_waddr_o);
    end
    drive(RES_LOGIC, OP_NOR, 32'h0000_ff00, 32'h0000_00ff, 5'd4, 1'b1);
    tick();
    n_checks++;
    if (mem_wdata_o !== 32'h0000_ffff || mem_we_o !== 1'b1 || mem_waddr_o !== 5'd3) begin
      n_fail++;
      $display("FAIL or_mem: got %h/%b/%0d, need 0000ffff/1/3", mem_wdata_o, mem_we_o,
               mem_waddr_o);
    end
    n_checks++;
    if (ex_wdata_o !== 32'hffff_0000) begin
      n_fail++;
      $display("FAIL nor_ex: got %h, need ffff0000", ex_wdata_o);
    end
    drive(RES_LOGIC, OP_XOR, 32'haaaa_aaaa, 32'hffff_0000, 5'd6, 1'b1);
    tick();
    n_checks++;
    if (ex_wdata_o !== 32'h5555_aaaa || ex_waddr_o !== 5'd6) begin
      n_fail++;
      $display("FAIL xor_ex: got %h/%0d, need 5555aaaa/6", ex_wdata_o, ex_waddr_o);
    end
    drive(RES_LOGIC, OP_AND, 32'hf0f0_1234, 32'h0ff0_ffff, 5'd7, 1'b1);
    tick();
    n_checks++;
    if (ex_wdata_o !== 32'h00f0_1234) begin
      n_fail++;
      $display("FAIL and_ex: got %h, need 00f01234", ex_wdata_o);
    end
    nop(); tick();
  endtask

  task automatic test_shift();
    logic [7:0]  ops [4];
    logic [31:0] sas [4];
    logic [31:0] exp [4];
    ops = '{OP_SLL, OP_SRL, OP_SRA, OP_SLL};
    sas = '{32'd4, 32'd4, 32'd4, 32'h24};
    exp = '{32'h0000_0100, 32'h0800_0001, 32'hf800_0001, 32'h0000_0100};
    for (int i = 0; i < 4; i++) begin
      drive(RES_SHIFT, ops[i], sas[i], 32'h8000_0010, 5'd9, 1'b1);
      tick();
      n_checks++;
      if (ex_wdata_o !== exp[i] || ex_we_o !== 1'b1) begin
        n_fail++;
        $display("FAIL shift_%0d: got %h/%b, need %h/1", i, ex_wdata_o, ex_we_o, exp[i]);
      end
    end
    drive(RES_SHIFT, OP_SRA, 32'd31, 32'h7fff_ffff, 5'd9, 1'b1);
    tick();
    n_checks++;
    if (ex_wdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL sra_pos31: got %h, need 00000000", ex_wdata_o);
    end
    nop(); tick();
  endtask

  task automatic test_stall();
    drive(RES_LOGIC, OP_OR, 32'h0000_1200, 32'h0000_0034, 5'd5, 1'b1);
    tick();
    drive(RES_LOGIC, OP_OR, 32'hdead_0000, 32'h0, 5'd10, 1'b1);
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (ex_wdata_o !== 32'h1234 || ex_we_o !== 1'b1 || ex_waddr_o !== 5'd5
          || mem_we_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_%0d: ex=%h/%b/%0d mem_we=%b, need 00001234/1/5 mem_we 0", i,
                 ex_wdata_o, ex_we_o, ex_waddr_o, mem_we_o);
      end
    end
    stall_i = 1'b0;
    nop();
    tick();
    n_checks++;
    if (mem_wdata_o !== 32'h1234 || mem_we_o !== 1'b1 || mem_waddr_o !== 5'd5) begin
      n_fail++;
      $display("FAIL stall_release: mem=%h/%b/%0d, need 00001234/1/5", mem_wdata_o, mem_we_o,
               mem_waddr_o);
    end
    tick();
    n_checks++;
    if (mem_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_once: mem_we=%b, need 0", mem_we_o);
    end
  endtask

  task automatic test_mem_stall();
    drive(RES_LOGIC, OP_AND, 32'h0000_ffff, 32'h0000_00ff, 5'd7, 1'b1);
    tick();
    drive(RES_LOGIC, OP_XOR, 32'h0000_000f, 32'h0000_00ff, 5'd8, 1'b1);
    tick();
    nop();
    mem_stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (mem_wdata_o !== 32'h00ff || mem_waddr_o !== 5'd7 || mem_we_o !== 1'b1
          || ex_wdata_o !== 32'h00f0 || ex_waddr_o !== 5'd8) begin
        n_fail++;
        $display("FAIL mem_stall_%0d: mem=%h/%0d/%b ex=%h/%0d, need 000000ff/7/1 000000f0/8",
                 i, mem_wdata_o, mem_waddr_o, mem_we_o, ex_wdata_o, ex_waddr_o);
      end
    end
    mem_stall_i = 1'b0;
    tick();
    n_checks++;
    if (mem_wdata_o !== 32'h00f0 || mem_waddr_o !== 5'd8) begin
      n_fail++;
      $display("FAIL mem_stall_release: mem=%h/%0d, need 000000f0/8", mem_wdata_o, mem_waddr_o);
    end
    tick();
  endtask

  task automatic test_zero_invalid();
    drive(RES_LOGIC, OP_OR, 32'h1, 32'h2, 5'd0, 1'b1);
    tick();
    n_checks++;
    if (ex_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_ex_we: got %b, need 0", ex_we_o);
    end
    drive(RES_LOGIC, OP_SLL, 32'h4, 32'hffff_ffff, 5'd11, 1'b1);
    tick();
    n_checks++;
    if (mem_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_mem_we: got %b, need 0", mem_we_o);
    end
    n_checks++;
    if (ex_wdata_o !== 32'h0 || ex_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_pair: got %h/%b, need 00000000/0", ex_wdata_o, ex_we_o);
    end
    nop(); tick(); tick();
  endtask

  task automatic test_flush_reset();
    drive(RES_LOGIC, OP_OR, 32'h0000_0f00, 32'h0, 5'd12, 1'b1);
    tick();
    drive(RES_LOGIC, OP_OR, 32'h0000_00f0, 32'h0, 5'd13, 1'b1);
    tick();
    flush_i = 1'b1; stall_i = 1'b1;
    tick();
    n_checks++;
    if (ex_we_o !== 1'b0 || ex_wdata_o !== 32'h0 || mem_we_o !== 1'b0 || mem_wdata_o !== 32'h0)
    begin
      n_fail++;
      $display("FAIL flush_stall: ex=%b/%h mem=%b/%h, need all 0", ex_we_o, ex_wdata_o,
               mem_we_o, mem_wdata_o);
    end
    flush_i = 1'b0; stall_i = 1'b0;
    drive(RES_LOGIC, OP_OR, 32'h0000_000f, 32'h0, 5'd14, 1'b1);
    tick();
    nop();
    tick();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({ex_waddr_o, ex_we_o, ex_wdata_o, mem_waddr_o, mem_we_o, mem_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: ex=%h/%b/%h mem=%h/%b/%h, need all 0", ex_waddr_o, ex_we_o,
               ex_wdata_o, mem_waddr_o, mem_we_o, mem_wdata_o);
    end
    rst = 1'b1;
  endtask

  initial begin
    nop(); stall_i = 0; mem_stall_i = 0; flush_i = 0;
    test_reset();
    test_logic();
    test_shift();
    test_stall();
    test_mem_stall();
    test_zero_invalid();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, sitting between the decoder and the memory stage.
- Internally latches the decoder's ID/EX bundle: alusel, aluop, reg1, reg2, waddr, we.
- Computes logic and shift results and registers them into the EX/MEM latch.
- Drives the ex_waddr/ex_we/ex_wdata forwarding bus back to the decoder.

Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-low
- id_alusel_i  in  3  result class from decoder (`EXE_RES_*`)
- id_aluop_i  in  8  operation subtype from decoder (`EXE_OP_*`)
- id_reg1_i  in  DATA_W  source operand 1 (shift amount for shifts)
- id_reg2_i  in  DATA_W  source operand 2 (shifted value for shifts)
- id_waddr_i  in  ADDR_W  destination register
- id_we_i  in  1  destination write enable
- stall_i  in  1  hold ID/EX latch; insert bubble into EX/MEM
- mem_stall_i  in  1  hold both ID/EX and EX/MEM latches
- flush_i  in  1  clear both latches to NOP
- ex_waddr_o  out  ADDR_W  forwarding: destination of instruction in EX
- ex_we_o  out  1  forwarding: write enable of instruction in EX
- ex_wdata_o  out  DATA_W  forwarding: result of instruction in EX
- mem_waddr_o  out  ADDR_W  EX/MEM latch destination
- mem_we_o  out  1  EX/MEM latch write enable
- mem_wdata_o  out  DATA_W  EX/MEM latch result

Behaviour:
- Reset (rst=0, asynchronous): both latches cleared.
  - alusel=`EXE_RES_NOP`, aluop=`EXE_OP_NOP_NOP`, operands 0, waddr 0, we 0.
  - All outputs read 0 while rst is low.
  - Reset mid-stall or mid-flush overrides everything.
- ID/EX latch update priority per clock: flush_i, then mem_stall_i, then stall_i, then load.
  - flush_i: clear to NOP.
  - mem_stall_i or stall_i: hold.
  - otherwise: load id_* inputs.
- EX/MEM latch update priority per clock: flush_i, then mem_stall_i, then stall_i, then load.
  - flush_i: clear.
  - mem_stall_i: hold.
  - stall_i: bubble (we=0, waddr=0, wdata=0).
  - otherwise: load the EX result.
- Compute (combinational on ID/EX latch contents):
  - LOGIC class:
    - AND → reg1 & reg2
    - OR → reg1 | reg2
    - XOR → reg1 ^ reg2
    - NOR → ~(reg1 | reg2)
  - SHIFT class (shift amount = reg1[4:0]; bits [31:5] ignored):
    - SLL → reg2 << sa
    - SRL → logical right shift of reg2
    - SRA → arithmetic right shift of reg2, sign = reg2[31]
  - NOP class, or any unlisted alusel/aluop pair → result 0, effective we forced 0.
- Forwarding bus = latch waddr, effective we, result. It updates in the same cycle the instruction enters EX.
- Effective we is 0 whenever waddr==0, so $0 is never forwarded or written.
- Latency:
  - id_* sampled at edge N.
  - ex_* valid after edge N.
  - mem_* valid after edge N+1.
  - Throughput 1 instruction/cycle.
- Stall/flush interaction:
  - During stall_i the instruction stays in EX and the forwarding bus stays asserted.
  - A stall held for k cycles inserts k bubbles downstream. The held instruction reaches mem_* exactly once, on the first non-stalled edge.
  - flush_i asserted together with either stall clears both latches.
- Back-to-back dependent instructions: results are consumed through the forwarding bus. No internal bypass is required.

Test Plan:
- Reset: drive rst=0 with random inputs → all ex_* and mem_* read 0. Release; NOPs clock through with mem_we_o=0.
- Logic ops: OR reg1=0x0000_FF00, reg2=0x0000_00FF, waddr=3 → after edge 1: ex_wdata=0x0000_FFFF, ex_we=1; after edge 2: mem_wdata=0x0000_FFFF, mem_waddr=3.
  - NOR of the same operands → 0xFFFF_0000.
  - XOR 0xAAAA_AAAA ^ 0xFFFF_0000 → 0x5555_AAAA.
- Shifts: reg2=0x8000_0010 with reg1=4 → SLL 0x0000_0100, SRL 0x0800_0001, SRA 0xF800_0001.
  - reg1=0x0000_0024 → shift amount 4; result identical to reg1=4.
- Stall: issue OR (result 0x1234) with waddr=5, assert stall_i for 2 cycles → ex_wdata holds 0x1234 and ex_we=1 throughout.
  - mem_we_o=0 for 2 cycles, then mem_wdata=0x1234 once.
  - mem_stall_i held 2 cycles instead → mem_* frozen on the prior instruction.
- $0 / invalid: OR with waddr=0 → ex_we=0, mem_we=0. alusel=LOGIC with aluop=SHIFT_SLL (invalid pair) → result 0, we 0.
- Flush and async reset:
  - flush_i asserted together with stall_i → both latches NOP on the next edge.
  - rst pulsed low mid-cycle → outputs clear immediately, without waiting for clk.
